// File: rtl/sap_host_cmd_sequencer.sv
// Host command sequencer: queues host commands and issues them to sap_full_system one at a
// time over the start/done handshake, capturing each result (or a watchdog abort) into a response slot.
module sap_host_cmd_sequencer #(
  parameter int INSTR_W     = 6,
  parameter int DATA_W      = 512,
  parameter int OUT_W       = 512,
  parameter int DEPTH       = 4,
  parameter int GAP_CYCLES  = 10,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [INSTR_W-1:0]       cmd_instr,
  input  logic [DATA_W-1:0]        cmd_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [INSTR_W-1:0]       rsp_instr,
  output logic [OUT_W-1:0]         rsp_data,
  output logic                     rsp_timeout,
  output logic [INSTR_W-1:0]       host_instruction,
  output logic [DATA_W-1:0]        host_data,
  output logic                     sap_start,
  input  logic                     sap_operation_done,
  input  logic [OUT_W-1:0]         sap_output,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0] GAP_LAST = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_DONE, S_WAIT_LOW, S_GAP} state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  data;
  } cmd_t;

  cmd_t               mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic               full, empty, push, issue;

  state_t             state_q, state_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               start_q, start_d;
  logic [INSTR_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0]  hd_q, hd_d;
  logic               rv_q, rv_d;
  logic [INSTR_W-1:0] ri_q, ri_d;
  logic [OUT_W-1:0]   rd_q, rd_d;
  logic               rt_q, rt_d;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // Acceptance looks only at fullness, so a same-cycle pop never frees a slot early.
  assign push  = cmd_valid && !full;

  always_comb begin
    count_d = count_q;
    case ({push, issue})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{instr: cmd_instr, data: cmd_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + AW'(1);
      if (issue) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    hi_d    = hi_q;
    hd_d    = hd_q;
    rv_d    = rv_q;
    ri_d    = ri_q;
    rd_d    = rd_q;
    rt_d    = rt_q;
    issue   = 1'b0;

    if (rv_q && rsp_ready) begin
      rv_d = 1'b0;
      ri_d = '0;
      rd_d = '0;
      rt_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        // Holding off while a response is pending keeps the slot from being overwritten.
        if (!empty && !rv_q && !sap_operation_done) begin
          issue   = 1'b1;
          hi_d    = mem_q[rd_ptr_q].instr;
          hd_d    = mem_q[rd_ptr_q].data;
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_q + 32'd1;
        if (sap_operation_done) begin
          start_d = 1'b0;
          hi_d    = '0;
          rd_d    = sap_output;
          ri_d    = hi_q;
          rt_d    = 1'b0;
          rv_d    = 1'b1;
          state_d = S_WAIT_LOW;
        end else if (cnt_q == TO_LAST) begin
          start_d = 1'b0;
          hi_d    = '0;
          rd_d    = '0;
          ri_d    = hi_q;
          rt_d    = 1'b1;
          rv_d    = 1'b1;
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_WAIT_LOW: begin
        if (!sap_operation_done) begin
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == GAP_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      hi_q    <= '0;
      hd_q    <= '0;
      rv_q    <= 1'b0;
      ri_q    <= '0;
      rd_q    <= '0;
      rt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      hi_q    <= hi_d;
      hd_q    <= hd_d;
      rv_q    <= rv_d;
      ri_q    <= ri_d;
      rd_q    <= rd_d;
      rt_q    <= rt_d;
    end
  end

  assign cmd_ready        = !full;
  assign rsp_valid        = rv_q;
  assign rsp_instr        = ri_q;
  assign rsp_data         = rd_q;
  assign rsp_timeout      = rt_q;
  assign host_instruction = hi_q;
  assign host_data        = hd_q;
  assign sap_start        = start_q;
  assign fifo_count       = count_q;
  assign busy             = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_sap_host_cmd_sequencer.sv
// Directed bench for sap_host_cmd_sequencer with a small SAP model that answers on the negedge.
module tb_sap_host_cmd_sequencer;
  localparam int IW = 6, DW = 64, OW = 64, DEP = 4, GAP = 4, TO = 64;

  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_timeout, sap_start, sap_operation_done, busy;
  logic [IW-1:0] cmd_instr, rsp_instr, host_instruction;
  logic [DW-1:0] cmd_data, host_data;
  logic [OW-1:0] rsp_data, sap_output;
  logic [2:0]    fifo_count;

  int checks = 0, errors = 0;
  int done_delay = 5, hold_extra = 0;
  bit never = 1'b0, block = 1'b0;
  logic [OW-1:0] model_base = 64'h8E;

  sap_host_cmd_sequencer #(.INSTR_W(IW), .DATA_W(DW), .OUT_W(OW), .DEPTH(DEP),
                           .GAP_CYCLES(GAP), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_instr(cmd_instr),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .host_instruction(host_instruction),
    .host_data(host_data), .sap_start(sap_start), .sap_operation_done(sap_operation_done),
    .sap_output(sap_output), .busy(busy), .fifo_count(fifo_count));

  always #5 clk = ~clk;

  // SAP model: raises done done_delay negedges after start, holds it hold_extra extra after start drops.
  initial begin
    int cnt, hcnt;
    cnt = 0; hcnt = 0;
    sap_operation_done = 1'b0;
    sap_output = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sap_operation_done = 1'b0; cnt = 0; hcnt = 0;
      end else if (block) begin
        sap_operation_done = 1'b1; hcnt = 0;
      end else if (sap_start && !sap_operation_done) begin
        cnt++;
        if (!never && cnt >= done_delay) begin
          sap_operation_done = 1'b1;
          sap_output = model_base + OW'(host_instruction);
          hcnt = 0;
        end
      end else if (!sap_start) begin
        cnt = 0;
        if (sap_operation_done) begin
          hcnt++;
          if (hcnt > hold_extra) sap_operation_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [IW-1:0] i, input logic [DW-1:0] d);
    cmd_instr = i; cmd_data = d; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(input logic lvl, input int limit, output int n);
    n = 0;
    while (sap_start !== lvl && n < limit) begin step(); n++; end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin step(); n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_wait: busy=%b exp 0", busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_instr = '0; cmd_data = '0; rsp_ready = 1'b0;
    repeat (2) step();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b exp 1", cmd_ready); end
    checks++; if ({rsp_valid, rsp_timeout, sap_start, busy} !== 4'b0) begin errors++;
      $display("FAIL reset_flags: got %b exp 0000", {rsp_valid, rsp_timeout, sap_start, busy}); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", fifo_count); end
    checks++; if ({host_instruction, host_data, rsp_data, rsp_instr} !== '0) begin errors++;
      $display("FAIL reset_data: hi=%h hd=%h rd=%h ri=%h exp 0", host_instruction, host_data, rsp_data, rsp_instr); end
    @(negedge clk); rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int n;
    rsp_ready = 1'b0;
    push(6'h17, 64'hFFFF_FFFF_FFFF_FF08);
    checks++; if (fifo_count !== 3'd1 || sap_start !== 1'b0) begin errors++;
      $display("FAIL single_queued: count=%0d start=%b exp 1/0", fifo_count, sap_start); end
    step();
    checks++; if (sap_start !== 1'b1 || host_instruction !== 6'h17 || host_data !== 64'hFFFF_FFFF_FFFF_FF08) begin errors++;
      $display("FAIL single_issue: start=%b hi=%h hd=%h exp 1/17/ffffffffffffff08", sap_start, host_instruction, host_data); end
    checks++; if (fifo_count !== 3'd0 || busy !== 1'b1) begin errors++;
      $display("FAIL single_pop: count=%0d busy=%b exp 0/1", fifo_count, busy); end
    wait_start(1'b0, 20, n);
    checks++; if (n != 5) begin errors++; $display("FAIL single_latency: got %0d exp 5", n); end
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'hA5 || rsp_instr !== 6'h17 || rsp_timeout !== 1'b0) begin errors++;
      $display("FAIL single_rsp: v=%b d=%h i=%h t=%b exp 1/a5/17/0", rsp_valid, rsp_data, rsp_instr, rsp_timeout); end
    checks++; if (host_instruction !== 6'h0 || host_data !== 64'hFFFF_FFFF_FFFF_FF08) begin errors++;
      $display("FAIL single_after: hi=%h hd=%h exp 0/ffffffffffffff08", host_instruction, host_data); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'hA5) begin errors++;
      $display("FAIL single_hold: v=%b d=%h exp 1/a5", rsp_valid, rsp_data); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== '0) begin errors++;
      $display("FAIL single_consume: v=%b d=%h exp 0/0", rsp_valid, rsp_data); end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] iss [8];
    logic [IW-1:0] rsp [8];
    int ni, nr, c, low_seen;
    logic prev_start, prev_done;
    rsp_ready = 1'b1; block = 1'b1;
    step();
    push(6'h11, 64'h1); push(6'h12, 64'h2); push(6'h13, 64'h3); push(6'h14, 64'h4);
    checks++; if (fifo_count !== 3'd4 || cmd_ready !== 1'b0 || sap_start !== 1'b0) begin errors++;
      $display("FAIL b2b_full: count=%0d ready=%b start=%b exp 4/0/0", fifo_count, cmd_ready, sap_start); end
    push(6'h15, 64'h5);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_refuse: count=%0d exp 4", fifo_count); end
    block = 1'b0;
    cmd_instr = 6'h15; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    checks++; if (fifo_count !== 3'd3 || sap_start !== 1'b1 || host_instruction !== 6'h11) begin errors++;
      $display("FAIL b2b_full_pop: count=%0d start=%b hi=%h exp 3/1/11", fifo_count, sap_start, host_instruction); end
    iss[0] = host_instruction; ni = 1; nr = 0; c = 0; low_seen = -100;
    prev_start = sap_start; prev_done = sap_operation_done;
    while ((nr < 4 || busy) && c < 400) begin
      step(); c++;
      if (prev_done && !sap_operation_done) low_seen = c;
      if (rsp_valid && nr < 8) begin
        checks++; if (rsp_data !== model_base + OW'(rsp_instr)) begin errors++;
          $display("FAIL b2b_rsp_data: got %h exp %h", rsp_data, model_base + OW'(rsp_instr)); end
        rsp[nr] = rsp_instr; nr++;
      end
      if (sap_start && !prev_start && ni < 8) begin
        iss[ni] = host_instruction; ni++;
        checks++; if (c - low_seen != GAP + 1) begin errors++;
          $display("FAIL b2b_gap: start %0d clk after done low exp %0d", c - low_seen, GAP + 1); end
      end
      prev_start = sap_start; prev_done = sap_operation_done;
    end
    checks++; if (ni != 4 || nr != 4) begin errors++; $display("FAIL b2b_counts: issued=%0d rsp=%0d exp 4/4", ni, nr); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (iss[k] !== IW'(8'h11 + k) || rsp[k] !== IW'(8'h11 + k)) begin errors++;
        $display("FAIL b2b_order[%0d]: issued=%h rsp=%h exp %h", k, iss[k], rsp[k], 8'h11 + k); end
    end
    rsp_ready = 1'b0;
    wait_idle();
  endtask

  task automatic test_rsp_stall();
    int n, bad;
    rsp_ready = 1'b0;
    push(6'h21, 64'h21); push(6'h22, 64'h22);
    checks++; if (fifo_count !== 3'd1 || sap_start !== 1'b1 || host_instruction !== 6'h21) begin errors++;
      $display("FAIL stall_issue: count=%0d start=%b hi=%h exp 1/1/21", fifo_count, sap_start, host_instruction); end
    wait_start(1'b0, 20, n);
    bad = 0;
    repeat (20) begin step(); if (sap_start !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_no_issue: start seen %0d cycles exp 0", bad); end
    checks++; if (fifo_count !== 3'd1 || rsp_valid !== 1'b1 || rsp_instr !== 6'h21) begin errors++;
      $display("FAIL stall_state: count=%0d v=%b ri=%h exp 1/1/21", fifo_count, rsp_valid, rsp_instr); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || sap_start !== 1'b0) begin errors++;
      $display("FAIL stall_consume: v=%b start=%b exp 0/0", rsp_valid, sap_start); end
    step();
    checks++; if (sap_start !== 1'b1 || host_instruction !== 6'h22 || fifo_count !== 3'd0) begin errors++;
      $display("FAIL stall_release: start=%b hi=%h count=%0d exp 1/22/0", sap_start, host_instruction, fifo_count); end
    wait_start(1'b0, 20, n);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    wait_idle();
  endtask

  task automatic test_timeout();
    int n;
    never = 1'b1; rsp_ready = 1'b0;
    push(6'h31, 64'h31); push(6'h32, 64'h32);
    wait_start(1'b0, 100, n);
    checks++; if (n != TO) begin errors++; $display("FAIL to_latency: got %0d exp %0d", n, TO); end
    checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_data !== '0 || rsp_instr !== 6'h31) begin errors++;
      $display("FAIL to_rsp: v=%b t=%b d=%h i=%h exp 1/1/0/31", rsp_valid, rsp_timeout, rsp_data, rsp_instr); end
    checks++; if (host_instruction !== 6'h0) begin errors++; $display("FAIL to_instr_clear: got %h exp 0", host_instruction); end
    never = 1'b0; rsp_ready = 1'b1;
    wait_start(1'b1, 30, n);
    checks++; if (n != GAP + 1 || host_instruction !== 6'h32 || rsp_valid !== 1'b0) begin errors++;
      $display("FAIL to_next: n=%0d hi=%h v=%b exp %0d/32/0", n, host_instruction, rsp_valid, GAP + 1); end
    wait_start(1'b0, 20, n);
    checks++; if (rsp_timeout !== 1'b0 || rsp_data !== model_base + 64'h32 || rsp_instr !== 6'h32) begin errors++;
      $display("FAIL to_recover: t=%b d=%h i=%h exp 0/%h/32", rsp_timeout, rsp_data, rsp_instr, model_base + 64'h32); end
    rsp_ready = 1'b0;
    step();
    wait_idle();
  endtask

  task automatic test_done_held();
    int n, lowat;
    hold_extra = 20; rsp_ready = 1'b1;
    push(6'h41, 64'h41); push(6'h42, 64'h42);
    wait_start(1'b0, 20, n);
    n = 0; lowat = -1;
    while (sap_start !== 1'b1 && n < 100) begin
      step(); n++;
      if (sap_operation_done === 1'b0 && lowat < 0) lowat = n;
    end
    checks++; if (lowat != 21) begin errors++; $display("FAIL held_low: done low after %0d exp 21", lowat); end
    checks++; if (n != 21 + GAP + 1 || host_instruction !== 6'h42) begin errors++;
      $display("FAIL held_issue: n=%0d hi=%h exp %0d/42", n, host_instruction, 21 + GAP + 1); end
    hold_extra = 0;
    wait_start(1'b0, 20, n);
    step();
    rsp_ready = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int n;
    never = 1'b1;
    push(6'h51, 64'h51); push(6'h52, 64'h52);
    step();
    checks++; if (sap_start !== 1'b1 || fifo_count !== 3'd1) begin errors++;
      $display("FAIL rstmid_pre: start=%b count=%0d exp 1/1", sap_start, fifo_count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (sap_start !== 1'b0 || fifo_count !== 3'd0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL rstmid_async: start=%b count=%0d v=%b ready=%b busy=%b exp 0/0/0/1/0",
               sap_start, fifo_count, rsp_valid, cmd_ready, busy); end
    @(negedge clk); rst = 1'b0; never = 1'b0;
    step();
    checks++; if (sap_start !== 1'b0 || host_instruction !== 6'h0) begin errors++;
      $display("FAIL rstmid_after: start=%b hi=%h exp 0/0", sap_start, host_instruction); end
    push(6'h13, 64'h99);
    step();
    checks++; if (sap_start !== 1'b1 || host_instruction !== 6'h13) begin errors++;
      $display("FAIL rstmid_reissue: start=%b hi=%h exp 1/13", sap_start, host_instruction); end
    wait_start(1'b0, 20, n);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'hA1 || rsp_instr !== 6'h13) begin errors++;
      $display("FAIL rstmid_rsp: v=%b d=%h i=%h exp 1/a1/13", rsp_valid, rsp_data, rsp_instr); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_rsp_stall();
    test_timeout();
    test_done_held();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
